// File: rtl/grid_io_pkg.sv
// Shared constants and state encoding for the multi-pad I/O tile.
package grid_io_pkg;

  // Position of each field inside one pad's group of configuration bits
  localparam int DIR_OFS      = 0;
  localparam int MODE_LO      = 1;
  localparam int MODE_HI      = 2;
  localparam int BITS_PER_PAD = 3;

  // Input capture modes; the value 2'b11 is not listed and behaves as MODE_COMB
  localparam logic [1:0] MODE_COMB = 2'b00;
  localparam logic [1:0] MODE_REG  = 2'b01;
  localparam logic [1:0] MODE_SYNC = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } cfg_state_e;

endpackage

// File: rtl/grid_io_multi_pad_if.sv
// Pad-side bundle of the tile: SoC pad signals and the fabric data paths.
interface grid_io_multi_pad_if #(
  parameter int NUM_PADS = 4
);
  logic [NUM_PADS-1:0] gfpga_pad_sofa_plus_io_SOC_IN;
  logic [NUM_PADS-1:0] gfpga_pad_sofa_plus_io_SOC_OUT;
  logic [NUM_PADS-1:0] gfpga_pad_sofa_plus_io_SOC_DIR;
  logic [NUM_PADS-1:0] outpad;
  logic [NUM_PADS-1:0] inpad;

  // Master side drives pad inputs and fabric data, observes tile outputs
  modport master (
    output gfpga_pad_sofa_plus_io_SOC_IN,
    output outpad,
    input  gfpga_pad_sofa_plus_io_SOC_OUT,
    input  gfpga_pad_sofa_plus_io_SOC_DIR,
    input  inpad
  );

  // Slave side is the tile itself
  modport slave (
    input  gfpga_pad_sofa_plus_io_SOC_IN,
    input  outpad,
    output gfpga_pad_sofa_plus_io_SOC_OUT,
    output gfpga_pad_sofa_plus_io_SOC_DIR,
    output inpad
  );
endinterface

// File: rtl/grid_io_pad_slice.sv
// One pad: active direction/mode bits, input capture pipeline, isolation gating.
module grid_io_pad_slice
  import grid_io_pkg::*;
(
  input  logic                    prog_clk,
  input  logic                    pReset,
  input  logic                    commit_en,
  input  logic [BITS_PER_PAD-1:0] cfg_bits,
  input  logic                    io_isol_n,
  input  logic                    soc_in,
  input  logic                    outpad,
  output logic                    soc_out,
  output logic                    soc_dir,
  output logic                    inpad
);

  logic       dir_q, dir_d;
  logic [1:0] mode_q, mode_d;
  logic       cap1_q, cap1_d;
  logic       cap2_q, cap2_d;
  logic       sel_in;

  // Next-state: active config loads only on a good commit; capture flops always run
  always_comb begin
    dir_d  = dir_q;
    mode_d = mode_q;
    if (commit_en) begin
      dir_d  = cfg_bits[DIR_OFS];
      mode_d = {cfg_bits[MODE_HI], cfg_bits[MODE_LO]};
    end
    cap1_d = soc_in;
    cap2_d = cap1_q;
  end

  // Register active config and capture pipeline; reset leaves the pad as an input
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      dir_q  <= 1'b1;
      mode_q <= MODE_COMB;
      cap1_q <= 1'b0;
      cap2_q <= 1'b0;
    end else begin
      dir_q  <= dir_d;
      mode_q <= mode_d;
      cap1_q <= cap1_d;
      cap2_q <= cap2_d;
    end
  end

  // Mode mux; the flops keep running so a mode change never inserts a bubble
  always_comb begin
    case (mode_q)
      MODE_REG:  sel_in = cap1_q;
      MODE_SYNC: sel_in = cap2_q;
      default:   sel_in = soc_in;
    endcase
  end

  assign soc_dir = ~io_isol_n | dir_q;
  assign soc_out = io_isol_n & outpad;
  assign inpad   = io_isol_n & sel_in;

endmodule

// File: rtl/grid_io_multi_pad.sv
// Multi-pad I/O tile: shadow configuration chain, bit counter and commit FSM.
//
// state  | meaning
// IDLE   | waiting; config_enable=1 starts a new load (first bit shifted here)
// SHIFT  | shifting bits in; config_enable=0 ends the load
// COMMIT | one cycle: copy shadow to active only if exactly CHAIN_LEN bits arrived
module grid_io_multi_pad
  import grid_io_pkg::*;
#(
  parameter int NUM_PADS = 4
) (
  input  logic                 prog_clk,
  input  logic                 pReset,
  input  logic                 IO_ISOL_N,
  input  logic                 config_enable,
  input  logic                 ccff_head,
  output logic                 ccff_tail,
  output logic                 cfg_loaded,
  output logic                 cfg_count_err,
  grid_io_multi_pad_if.slave   pads
);

  localparam int CHAIN_LEN = BITS_PER_PAD * NUM_PADS;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 2);
  // Saturating one past full makes any overshift read as a count error
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CHAIN_LEN + 1);

  cfg_state_e           state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
  logic                 loaded_q, loaded_d;
  logic                 err_q, err_d;
  logic                 commit_ok;

  // Next-state for chain, counter and commit flags
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    shadow_d  = shadow_q;
    loaded_d  = loaded_q;
    err_d     = err_q;
    commit_ok = 1'b0;
    case (state_q)
      IDLE: begin
        if (config_enable) begin
          shadow_d = {shadow_q[CHAIN_LEN-2:0], ccff_head};
          count_d  = CNT_W'(1);
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (config_enable) begin
          shadow_d = {shadow_q[CHAIN_LEN-2:0], ccff_head};
          count_d  = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
        end else begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        state_d = IDLE;
        if (count_q == CNT_FULL) begin
          commit_ok = 1'b1;
          loaded_d  = 1'b1;
          err_d     = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, counter, shadow chain and status flags
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      shadow_q <= '0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      shadow_q <= shadow_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
    end
  end

  assign ccff_tail     = shadow_q[CHAIN_LEN-1];
  assign cfg_loaded    = loaded_q;
  assign cfg_count_err = err_q;

  for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
    grid_io_pad_slice u_slice (
      .prog_clk  (prog_clk),
      .pReset    (pReset),
      .commit_en (commit_ok),
      .cfg_bits  (shadow_q[BITS_PER_PAD*i +: BITS_PER_PAD]),
      .io_isol_n (IO_ISOL_N),
      .soc_in    (pads.gfpga_pad_sofa_plus_io_SOC_IN[i]),
      .outpad    (pads.outpad[i]),
      .soc_out   (pads.gfpga_pad_sofa_plus_io_SOC_OUT[i]),
      .soc_dir   (pads.gfpga_pad_sofa_plus_io_SOC_DIR[i]),
      .inpad     (pads.inpad[i])
    );
  end

endmodule

// File: tb/tb_grid_io_multi_pad.sv
// Directed bench for grid_io_multi_pad with a cycle-level reference model.
module tb_grid_io_multi_pad;

  localparam int NP = 4;
  localparam int CL = 3 * NP;

  logic prog_clk = 1'b0;
  logic pReset, IO_ISOL_N, config_enable, ccff_head;
  logic ccff_tail, cfg_loaded, cfg_count_err;

  int checks = 0;
  int errors = 0;

  grid_io_multi_pad_if #(.NUM_PADS(NP)) pads ();

  grid_io_multi_pad #(.NUM_PADS(NP)) dut (
    .prog_clk      (prog_clk),
    .pReset        (pReset),
    .IO_ISOL_N     (IO_ISOL_N),
    .config_enable (config_enable),
    .ccff_head     (ccff_head),
    .ccff_tail     (ccff_tail),
    .cfg_loaded    (cfg_loaded),
    .cfg_count_err (cfg_count_err),
    .pads          (pads)
  );

  always #5 prog_clk = ~prog_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks a load session as "bits shifted since the session began" (plain int),
  // a pending commit one cycle after config_enable drops, and SOC_IN history.
  logic [CL-1:0] m_shadow, m_active;
  logic [NP-1:0] m_d1, m_d2;
  bit m_loaded, m_err, m_sess, m_cpend, m_valid = 0;
  int m_nbits;

  function automatic logic [CL-1:0] active_reset();
    logic [CL-1:0] v = '0;
    for (int i = 0; i < NP; i++) v[3*i] = 1'b1;
    return v;
  endfunction

  always @(posedge prog_clk) begin
    if (pReset) begin
      m_shadow = '0; m_active = active_reset(); m_d1 = '0; m_d2 = '0;
      m_loaded = 0; m_err = 0; m_sess = 0; m_cpend = 0; m_nbits = 0; m_valid = 1;
    end else begin
      m_d2 = m_d1;
      m_d1 = pads.gfpga_pad_sofa_plus_io_SOC_IN;
      if (m_cpend) begin
        if (m_nbits == CL) begin m_active = m_shadow; m_loaded = 1; m_err = 0; end
        else m_err = 1;
        m_cpend = 0; m_sess = 0;
      end else if (config_enable) begin
        m_shadow = {m_shadow[CL-2:0], ccff_head};
        m_nbits = m_sess ? m_nbits + 1 : 1;
        m_sess = 1;
      end else if (m_sess) begin
        m_cpend = 1;
      end
    end
  end

  function automatic logic [NP-1:0] exp_inpad();
    logic [NP-1:0] r;
    for (int i = 0; i < NP; i++) begin
      int mode = 2 * int'(m_active[3*i+2]) + int'(m_active[3*i+1]);
      logic v = (mode == 1) ? m_d1[i] : (mode == 2) ? m_d2[i] : pads.gfpga_pad_sofa_plus_io_SOC_IN[i];
      r[i] = IO_ISOL_N & v;
    end
    return r;
  endfunction

  function automatic logic [NP-1:0] exp_dir();
    logic [NP-1:0] r;
    for (int i = 0; i < NP; i++) r[i] = ~IO_ISOL_N | m_active[3*i];
    return r;
  endfunction

  // Per-cycle comparison against the model
  always @(negedge prog_clk) begin
    if (m_valid) begin
      check("m_dir",    32'(pads.gfpga_pad_sofa_plus_io_SOC_DIR), 32'(exp_dir()));
      check("m_out",    32'(pads.gfpga_pad_sofa_plus_io_SOC_OUT),
            32'(IO_ISOL_N ? pads.outpad : '0));
      check("m_inpad",  32'(pads.inpad), 32'(exp_inpad()));
      check("m_tail",   32'(ccff_tail), 32'(m_shadow[CL-1]));
      check("m_loaded", 32'(cfg_loaded), 32'(m_loaded));
      check("m_err",    32'(cfg_count_err), 32'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge prog_clk);
    #1;
  endtask

  // Shift v[n-1] first so v ends up as shadow[n-1:0]
  task automatic shift_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      config_enable = 1'b1;
      ccff_head = v[i];
      step();
    end
  endtask

  task automatic drop_and_commit();
    config_enable = 1'b0;
    step();
    step();
  endtask

  logic [23:0] pat;

  initial begin
    pReset = 1'b1; IO_ISOL_N = 1'b1; config_enable = 1'b0; ccff_head = 1'b0;
    pads.gfpga_pad_sofa_plus_io_SOC_IN = 4'b1010;
    pads.outpad = 4'b0110;
    step(); step();
    check("rst_inpad",  32'(pads.inpad), 32'h0000000a);
    check("rst_dir",    32'(pads.gfpga_pad_sofa_plus_io_SOC_DIR), 32'h0000000f);
    check("rst_out",    32'(pads.gfpga_pad_sofa_plus_io_SOC_OUT), 32'h00000006);
    check("rst_loaded", 32'(cfg_loaded), 32'h0);
    check("rst_err",    32'(cfg_count_err), 32'h0);
    check("rst_tail",   32'(ccff_tail), 32'h0);
    pReset = 1'b0;
    step();

    // Exact load: pad0 DIR=0 MODE=01, pads1-3 DIR=1 MODE=10
    shift_bits(32'b101_101_101_010, 12);
    drop_and_commit();
    check("load_dir",    32'(pads.gfpga_pad_sofa_plus_io_SOC_DIR), 32'h0000000e);
    check("load_loaded", 32'(cfg_loaded), 32'h1);
    check("load_err",    32'(cfg_count_err), 32'h0);
    pads.gfpga_pad_sofa_plus_io_SOC_IN = 4'b1001;
    #1;
    check("lat_p1_c0", 32'(pads.inpad[1]), 32'h1);
    check("lat_p0_c0", 32'(pads.inpad[0]), 32'h0);
    step();
    check("lat_p1_c1", 32'(pads.inpad[1]), 32'h1);
    check("lat_p0_c1", 32'(pads.inpad[0]), 32'h1);
    step();
    check("lat_p1_c2", 32'(pads.inpad[1]), 32'h0);

    // Short load then overshift: error, active unchanged
    shift_bits(32'h0, 11);
    drop_and_commit();
    check("short_err", 32'(cfg_count_err), 32'h1);
    check("short_dir", 32'(pads.gfpga_pad_sofa_plus_io_SOC_DIR), 32'h0000000e);
    step();
    shift_bits(32'h0, 13);
    drop_and_commit();
    check("over_err",    32'(cfg_count_err), 32'h1);
    check("over_dir",    32'(pads.gfpga_pad_sofa_plus_io_SOC_DIR), 32'h0000000e);
    check("over_loaded", 32'(cfg_loaded), 32'h1);

    // Back-to-back: enable high during COMMIT must not shift that bit
    shift_bits(32'b011_011_011_011, 12);
    config_enable = 1'b0;
    step();
    config_enable = 1'b1; ccff_head = 1'b1;
    step();
    check("b2b_dir1", 32'(pads.gfpga_pad_sofa_plus_io_SOC_DIR), 32'h0000000f);
    check("b2b_err1", 32'(cfg_count_err), 32'h0);
    shift_bits(32'b110_000_000_000, 12);
    drop_and_commit();
    check("b2b_dir2", 32'(pads.gfpga_pad_sofa_plus_io_SOC_DIR), 32'h00000000);
    check("b2b_err2", 32'(cfg_count_err), 32'h0);
    pads.gfpga_pad_sofa_plus_io_SOC_IN = 4'b0110;
    #1;
    check("mode11_comb", 32'(pads.inpad), 32'h00000006);

    // Isolation is immediate and reversible
    pads.outpad = 4'b1011;
    IO_ISOL_N = 1'b0;
    #1;
    check("iso_dir",   32'(pads.gfpga_pad_sofa_plus_io_SOC_DIR), 32'h0000000f);
    check("iso_out",   32'(pads.gfpga_pad_sofa_plus_io_SOC_OUT), 32'h0);
    check("iso_inpad", 32'(pads.inpad), 32'h0);
    step();
    IO_ISOL_N = 1'b1;
    #1;
    check("uniso_dir",   32'(pads.gfpga_pad_sofa_plus_io_SOC_DIR), 32'h0);
    check("uniso_out",   32'(pads.gfpga_pad_sofa_plus_io_SOC_OUT), 32'h0000000b);
    check("uniso_inpad", 32'(pads.inpad), 32'h00000006);
    step();

    // Chain pass-through: bit j reaches ccff_tail after shift j+11
    pat = 24'hB35AE1;
    for (int j = 0; j < 24; j++) begin
      config_enable = 1'b1;
      ccff_head = pat[j];
      step();
      if (j >= 11) check("pass_tail", 32'(ccff_tail), 32'(pat[j-11]));
    end
    drop_and_commit();
    check("pass_err", 32'(cfg_count_err), 32'h1);
    check("pass_dir", 32'(pads.gfpga_pad_sofa_plus_io_SOC_DIR), 32'h0);

    // Reset mid-shift: no partial commit, FSM back to IDLE with count cleared
    shift_bits(32'h3f, 6);
    pReset = 1'b1; config_enable = 1'b0;
    step();
    pReset = 1'b0;
    check("mrst_dir",    32'(pads.gfpga_pad_sofa_plus_io_SOC_DIR), 32'h0000000f);
    check("mrst_tail",   32'(ccff_tail), 32'h0);
    check("mrst_loaded", 32'(cfg_loaded), 32'h0);
    check("mrst_err",    32'(cfg_count_err), 32'h0);
    step(); step(); step();
    check("mrst_idle_err", 32'(cfg_count_err), 32'h0);
    shift_bits(32'b101_101_101_010, 12);
    drop_and_commit();
    check("reload_dir",    32'(pads.gfpga_pad_sofa_plus_io_SOC_DIR), 32'h0000000e);
    check("reload_loaded", 32'(cfg_loaded), 32'h1);
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/grid_io_multi_pad.md
# grid_io_multi_pad

Parametrised multi-pad I/O tile for the fabric perimeter. It replaces the single-pad io tile with NUM_PADS pads that share one configuration chain segment. Each pad gets its own direction bit and input-capture mode: combinational, registered, or 2-flop synchroniser. A shadow/active configuration scheme with a bit counter commits a new configuration only after exactly the right number of bits has been shifted.

## Interface
- NUM_PADS, default 4: number of pads in the tile; legal range 1–32.
- CHAIN_LEN (localparam): 3*NUM_PADS configuration bits.
- prog_clk  in  1  single clock, used for both the chain and the input capture.
- pReset  in  1  synchronous, active-high reset.
- IO_ISOL_N  in  1  active-low isolation; 0 forces every pad into the safe state.
- config_enable  in  1  1 = shift the chain this cycle.
- ccff_head  in  1  chain serial input.
- ccff_tail  out  1  chain serial output: the registered shadow[CHAIN_LEN-1].
- gfpga_pad_sofa_plus_io_SOC_IN  in  NUM_PADS  pad input from the SoC.
- gfpga_pad_sofa_plus_io_SOC_OUT  out  NUM_PADS  pad output to the SoC.
- gfpga_pad_sofa_plus_io_SOC_DIR  out  NUM_PADS  1 = pad is input (driver off).
- outpad  in  NUM_PADS  fabric data to be driven onto the pads.
- inpad  out  NUM_PADS  pad data delivered to the fabric.
- cfg_loaded  out  1  sticky; set by the first successful commit.
- cfg_count_err  out  1  result of the last commit: 1 = wrong bit count.

## Operation
- **Shadow chain layout.**
  - Each cycle with config_enable=1, shadow shifts: shadow[0] <= ccff_head and shadow[k] <= shadow[k-1].
  - Pad i occupies bits 3i..3i+2: 3i = DIR, 3i+1 = MODE[0], 3i+2 = MODE[1].
- **State machine.**
  - IDLE: if config_enable=1, shift, set count <= 1, go to SHIFT.
  - SHIFT: if config_enable=1, shift and set count <= min(count+1, CHAIN_LEN+1). If config_enable=0, do not shift and go to COMMIT.
  - COMMIT (one cycle):
    - If count == CHAIN_LEN: active <= shadow, cfg_loaded <= 1, cfg_count_err <= 0.
    - Otherwise: active is unchanged and cfg_count_err <= 1.
    - Next state is always IDLE. config_enable=1 during COMMIT causes neither a shift nor a count.
- **Counter.** Width is $clog2(CHAIN_LEN+2). It saturates at CHAIN_LEN+1, so any overshift reads as an error.
- **Input path per pad.** Selected by active MODE:
  - 00: combinational.
  - 01: one prog_clk flop.
  - 10: two flops.
  - 11: treated as 00.
  - The capture flops run every cycle regardless of mode.
- **Outputs.**
  - SOC_DIR[i] = ~IO_ISOL_N | active.DIR[i].
  - SOC_OUT[i] = IO_ISOL_N ? outpad[i] : 0.
  - inpad[i] = IO_ISOL_N ? mode-muxed value : 0.
  - Isolation is combinational and overrides everything.
- **Reset values.**
  - shadow = 0; ccff_tail = 0.
  - active DIR = 1 and MODE = 00 for every pad.
  - Capture flops = 0; state = IDLE; count = 0.
  - cfg_loaded = 0; cfg_count_err = 0.
  - Resulting outputs: SOC_DIR all 1; SOC_OUT = outpad gated by IO_ISOL_N; inpad = SOC_IN gated.

## Timing
- **Chain.** ccff_tail changes one cycle after each shift. A bit entering at ccff_head appears at ccff_tail after CHAIN_LEN shifts.
- **Commit.** The new configuration drives SOC_DIR and the input mux from the cycle after COMMIT, i.e. 2 cycles after config_enable falls.
- **Input latency** from SOC_IN to inpad: 0, 1 or 2 cycles for MODE 00, 01 and 10.
  - On a mode change, capture-flop contents stay valid because the flops run continuously. No bubble is inserted.
- **Reset mid-shift or at COMMIT.** Everything returns to its reset values and no partial commit occurs.
- **Back-to-back loads.** A one-cycle low pulse of config_enable gives SHIFT → COMMIT → IDLE.
  - If config_enable is high during COMMIT, that cycle is not shifted.
  - Shifting resumes from IDLE on the following cycle.
- **Isolation** has zero-cycle effect and does not disturb chain state.

## Structure
- Package grid_io_pkg holds:
  - field offsets: DIR_OFS=0, MODE_LO=1, MODE_HI=2, BITS_PER_PAD=3;
  - mode encodings: MODE_COMB, MODE_REG, MODE_SYNC;
  - the state enum: IDLE, SHIFT, COMMIT.
- Sub-module grid_io_pad_slice, instantiated NUM_PADS times, contains:
  - the active DIR and MODE bits with their commit enable;
  - the two capture flops and the mode mux;
  - the isolation gating.
- The top level holds the shadow chain, counter and FSM.

## Test plan
- **Reset.** Drive NUM_PADS=4 with SOC_IN=4'b1010 and IO_ISOL_N=1 → inpad=4'b1010 combinationally; SOC_DIR=4'b1111; cfg_loaded=0.
- **Exact load.** Shift 12 bits giving pad0 DIR=0 with MODE=01 and pads 1–3 DIR=1 with MODE=10, then drop config_enable.
  - After 2 cycles: SOC_DIR=4'b1110, cfg_loaded=1, cfg_count_err=0.
  - A SOC_IN[1] edge reaches inpad[1] after exactly 2 cycles.
- **Short and overshift.** Shift 11 bits, then commit → cfg_count_err=1 and active is unchanged. Repeat with 13 bits → same result.
- **Chain pass-through.** Shift a 24-bit pattern → ccff_tail reproduces the first 12 bits, delayed by 12 cycles.
- **Isolation.** With configuration loaded, drive IO_ISOL_N=0 → same cycle SOC_DIR=4'b1111, SOC_OUT=0, inpad=0. Release it → previous behaviour resumes.
- **Reset mid-shift.** Assert pReset after 6 shifts → state IDLE, count 0, active at reset values, ccff_tail=0.
